fm_freq_demod: RTL and testbench

//  Receive side of the FM distance link: recovers distance from the FM square wave
//  (comparator output of the NCO sine, ~290-310 kHz).
//  - Synchronises the input and counts its rising edges over a fixed gate window.
//  - Maps the edge count linearly back to distance and presents it on a valid/ready output.
//  - Sits between the comparator input pin and the display/scope path.

---
 rtl/fm_freq_demod.sv | 174 +++++++++++++++++
 tb/tb_fm_freq_demod.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_freq_demod.sv
// fm_freq_demod
//   Receive side of the FM distance link. The comparator output of the NCO
//   sine (~290-310 kHz) is synchronised, and its rising edges are counted over
//   a fixed gate window. The count is mapped linearly back to a distance and
//   presented on a valid/ready output.
//
// Ports
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   enable        in   1 = run measurements, 0 = go idle after current handshake
//   fm_in         in   asynchronous FM square wave
//   ready         in   downstream accepts result
//   valid         out  result (distance, edge_count, out_of_range) is valid
//   distance      out  recovered distance, 0..MAX_DIST
//   edge_count    out  raw rising-edge count of the last window
//   out_of_range  out  edge_count < LOW_COUNT or > HIGH_COUNT
//   busy          out  1 while in GATE or CONVERT
module fm_freq_demod #(
    parameter int unsigned WIDTH          = 13,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned GATE_CYCLES    = 50000,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned LOW_COUNT      = 290,
    parameter int unsigned HIGH_COUNT     = 310,
    parameter int unsigned DIST_PER_COUNT = 100,
    parameter int unsigned MAX_DIST       = 2000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fm_in,
    input  logic                 ready,
    output logic                 valid,
    output logic [WIDTH-1:0]     distance,
    output logic [CNT_WIDTH-1:0] edge_count,
    output logic                 out_of_range,
    output logic                 busy
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES + 1);
    localparam int unsigned PROD_W = CNT_WIDTH + WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        CONVERT,
        PRESENT
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;

    logic [GATE_W-1:0]      gate_cnt;
    logic [CNT_WIDTH-1:0]   edge_cnt;
    logic                   gate_last;
    logic                   handshake;
    logic                   clear_cnt;

    logic [PROD_W-1:0]      excess;
    logic [PROD_W-1:0]      product;
    logic [WIDTH-1:0]       dist_calc;
    logic                   oor_calc;

    // Input synchroniser followed by one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], fm_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise      = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign gate_last = (gate_cnt == GATE_W'(GATE_CYCLES - 1));
    assign handshake = valid & ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        clear_cnt = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d   = GATE;
                    clear_cnt = 1'b1;
                end
            end
            GATE: begin
                busy = 1'b1;
                if (!enable) begin
                    state_d = IDLE;
                end else if (gate_last) begin
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                busy    = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (handshake) begin
                    state_d   = enable ? GATE : IDLE;
                    clear_cnt = enable;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counting stops the moment enable drops; an aborted window is cleared
    // again on the next entry to GATE, so its partial counts never escape.
    always_ff @(posedge clk) begin
        if (reset) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else if (clear_cnt) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else if (state_q == GATE && enable) begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            if (rise && edge_cnt != '1) begin
                edge_cnt <= edge_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Distance mapping; the product is kept at full width so the clamp sees
    // the true value even when it exceeds the output width.
    always_comb begin
        excess    = PROD_W'(edge_cnt) - PROD_W'(LOW_COUNT);
        product   = excess * PROD_W'(DIST_PER_COUNT);
        oor_calc  = (32'(edge_cnt) < LOW_COUNT) || (32'(edge_cnt) > HIGH_COUNT);
        dist_calc = '0;
        if (32'(edge_cnt) <= LOW_COUNT) begin
            dist_calc = '0;
        end else if (32'(edge_cnt) >= HIGH_COUNT) begin
            dist_calc = WIDTH'(MAX_DIST);
        end else if (product > PROD_W'(MAX_DIST)) begin
            dist_calc = WIDTH'(MAX_DIST);
        end else begin
            dist_calc = product[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid        <= 1'b0;
            distance     <= '0;
            edge_count   <= '0;
            out_of_range <= 1'b0;
        end else if (state_q == CONVERT) begin
            valid        <= 1'b1;
            distance     <= dist_calc;
            edge_count   <= edge_cnt;
            out_of_range <= oor_calc;
        end else if (state_q == PRESENT && handshake) begin
            valid        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fm_freq_demod.sv
// tb_fm_freq_demod
//   Self-checking bench for fm_freq_demod using a shortened gate window.
//   The reference model records the sampled fm_in per clock and counts the
//   0->1 transitions whose synchronised arrival falls inside each window.
module tb_fm_freq_demod;

    localparam int unsigned W   = 13;
    localparam int unsigned CW  = 16;
    localparam int          G   = 720;
    localparam int unsigned SS  = 2;
    localparam int          LO  = 20;
    localparam int          HI  = 40;
    localparam int          DPC = 100;
    localparam int          MX  = 1500;
    localparam int          CNT_MAX = (1 << CW) - 1;
    localparam int          HIST_N  = 32768;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          fm_in;
    logic          ready;
    logic          valid;
    logic [W-1:0]  distance;
    logic [CW-1:0] edge_count;
    logic          out_of_range;
    logic          busy;

    typedef enum int {G_ZERO, G_SQ, G_RND, G_STEP} gen_t;

    gen_t gen_mode;
    int   per;
    int   phase;
    int   tog_k;
    int   step_at;
    int   total;
    int   bad;
    int   cyc;
    int   last_rst;
    bit   hist [0:HIST_N-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fm_freq_demod #(
        .WIDTH(W),
        .CNT_WIDTH(CW),
        .GATE_CYCLES(G),
        .SYNC_STAGES(SS),
        .LOW_COUNT(LO),
        .HIGH_COUNT(HI),
        .DIST_PER_COUNT(DPC),
        .MAX_DIST(MX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .fm_in(fm_in),
        .ready(ready),
        .valid(valid),
        .distance(distance),
        .edge_count(edge_count),
        .out_of_range(out_of_range),
        .busy(busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Sampled input as the synchroniser sees it: reset wipes its history.
    function automatic bit h(input int m);
        if (m < 0 || m <= last_rst || m >= HIST_N) return 1'b0;
        return hist[m];
    endfunction

    // A 0->1 change sampled at edges m-1 -> m is counted at edge m+2.
    function automatic int model_count(input int p);
        int c = 0;
        for (int n = p + 1; n <= p + G; n++) begin
            if (h(n - 2) && !h(n - 3)) c++;
        end
        if (c > CNT_MAX) c = CNT_MAX;
        return c;
    endfunction

    function automatic int model_dist(input int c);
        if (c <= LO) return 0;
        if (c >= HI) return MX;
        if ((c - LO) * DPC > MX) return MX;
        return (c - LO) * DPC;
    endfunction

    function automatic int model_oor(input int c);
        return (c < LO || c > HI) ? 1 : 0;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            if (cyc < HIST_N) hist[cyc] = fm_in;
            if (reset) last_rst = cyc;
            #1;
            case (gen_mode)
                G_ZERO: fm_in = 1'b0;
                G_SQ:   fm_in = (((cyc + 1 + phase) % per) < (per / 2));
                G_RND:  if ($urandom_range(tog_k - 1, 0) == 0) fm_in = ~fm_in;
                G_STEP: fm_in = ((cyc + 1) >= step_at);
                default: fm_in = 1'b0;
            endcase
        end
    endtask

    // p is the edge at which the DUT leaves IDLE/PRESENT for GATE.
    task automatic collect(input string tag, input int p, output int c);
        step(p + G - cyc);
        check({tag, ".busy_convert"}, int'(busy), 1);
        check({tag, ".valid_early"}, int'(valid), 0);
        step(1);
        c = model_count(p);
        check({tag, ".valid"}, int'(valid), 1);
        check({tag, ".edge_count"}, int'(edge_count), c);
        check({tag, ".distance"}, int'(distance), model_dist(c));
        check({tag, ".oor"}, int'(out_of_range), model_oor(c));
        check({tag, ".busy_present"}, int'(busy), 0);
    endtask

    task automatic to_idle(input string tag);
        enable = 1'b0;
        ready  = 1'b1;
        step(1);
        check({tag, ".valid_after_hs"}, int'(valid), 0);
        check({tag, ".busy_idle"}, int'(busy), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, int'(valid), 0);
        check({tag, ".distance"}, int'(distance), 0);
        check({tag, ".edge_count"}, int'(edge_count), 0);
        check({tag, ".oor"}, int'(out_of_range), 0);
        check({tag, ".busy"}, int'(busy), 0);
    endtask

    task automatic sq_window(input string tag, input int pp, output int c);
        int p;
        gen_mode = G_SQ;
        per      = pp;
        phase    = $urandom_range(pp - 1, 0);
        step(5);
        enable = 1'b1;
        p = cyc + 1;
        collect(tag, p, c);
    endtask

    int tper [7] = '{72, 36, 30, 24, 20, 18, 16};
    int tcnt [7] = '{10, 20, 24, 30, 36, 40, 45};

    initial begin
        int p;
        int c;
        total    = 0;
        bad      = 0;
        cyc      = 0;
        last_rst = -1;
        gen_mode = G_ZERO;
        per      = 2;
        phase    = 0;
        tog_k    = 8;
        step_at  = 0;
        reset    = 1'b1;
        enable   = 1'b0;
        ready    = 1'b0;
        fm_in    = 1'b0;

        step(3);
        check_zero("reset");
        reset = 1'b0;
        step(2);
        check_zero("idle");

        // Back-to-back windows with ready high: period is G+2.
        ready = 1'b1;
        sq_window("b2b0", 24, c);
        check("b2b0.const", int'(edge_count), 30);
        check("b2b0.dist_const", int'(distance), 1000);
        step(1);
        check("b2b.valid_drop", int'(valid), 0);
        check("b2b.busy_restart", int'(busy), 1);
        p = cyc;
        collect("b2b1", p, c);
        check("b2b1.const", int'(edge_count), 30);
        to_idle("b2b");

        // Table of exact counts around the mapping boundaries.
        for (int i = 0; i < 7; i++) begin
            sq_window($sformatf("tbl%0d", i), tper[i], c);
            check($sformatf("tbl%0d.const", i), int'(edge_count), tcnt[i]);
            to_idle($sformatf("tbl%0d", i));
        end

        // Stuck-low input.
        gen_mode = G_ZERO;
        step(5);
        enable = 1'b1;
        p = cyc + 1;
        collect("zero", p, c);
        check("zero.const_cnt", int'(edge_count), 0);
        check("zero.const_oor", int'(out_of_range), 1);
        to_idle("zero");

        // Random toggle density.
        for (int i = 0; i < 4; i++) begin
            gen_mode = G_RND;
            tog_k    = $urandom_range(40, 8);
            step(5);
            enable = 1'b1;
            p = cyc + 1;
            collect($sformatf("rnd%0d", i), p, c);
            to_idle($sformatf("rnd%0d", i));
        end

        // A rise arriving on the last gate cycle counts; one cycle later does not.
        for (int i = 0; i < 2; i++) begin
            gen_mode = G_ZERO;
            step(5);
            enable   = 1'b1;
            p        = cyc + 1;
            step_at  = p + G - 2 + i;
            gen_mode = G_STEP;
            collect($sformatf("edge%0d", i), p, c);
            check($sformatf("edge%0d.const", i), int'(edge_count), 1 - i);
            to_idle($sformatf("edge%0d", i));
        end

        // Backpressure: result held, no new window while ready is low.
        ready = 1'b0;
        sq_window("bp", 20, c);
        for (int i = 0; i < 200; i++) begin
            step(1);
            check("bp.valid_hold", int'(valid), 1);
            check("bp.dist_hold", int'(distance), model_dist(c));
            check("bp.cnt_hold", int'(edge_count), c);
            check("bp.busy_low", int'(busy), 0);
        end
        ready = 1'b1;
        step(1);
        check("bp.valid_drop", int'(valid), 0);
        check("bp.busy_restart", int'(busy), 1);

        // Abort mid-window with enable low.
        step(200);
        enable = 1'b0;
        step(1);
        check("abort.busy", int'(busy), 0);
        for (int i = 0; i < G + 10; i++) begin
            step(1);
            check("abort.valid_low", int'(valid), 0);
        end
        enable = 1'b1;
        p = cyc + 1;
        collect("fresh", p, c);
        check("fresh.const", int'(edge_count), 36);

        // Reset during GATE.
        step(1);
        check("rstg.busy_before", int'(busy), 1);
        step(100);
        reset = 1'b1;
        step(1);
        check_zero("rst_gate");
        reset = 1'b0;
        ready = 1'b0;
        p = cyc + 1;
        collect("after_rst", p, c);

        // Reset during PRESENT.
        reset = 1'b1;
        step(1);
        check_zero("rst_present");
        reset  = 1'b0;
        enable = 1'b0;
        step(2);
        check("end.valid", int'(valid), 0);
        check("end.busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
